// File: rtl/camera_vip_packetizer.sv
// Buffers a free-running camera pixel stream in a FIFO and emits Avalon-ST Video packets
// (optional control packet, then video packet) with frame and truncation counters.
module camera_vip_packetizer #(
    parameter int         BPS           = 8,
    parameter int         CHANNELS      = 3,
    parameter int         VIDEO_W       = 1280,
    parameter int         VIDEO_H       = 720,
    parameter int         FIFO_DEPTH    = 1024,
    parameter int         EMIT_CTRL     = 1,
    parameter logic [3:0] INTERLACE     = 4'h0,
    parameter int         READY_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pix_valid,
    input  logic                    pix_sof,
    input  logic [BPS*CHANNELS-1:0] pix_data,
    output logic [BPS*CHANNELS-1:0] st_data,
    output logic                    st_valid,
    output logic                    st_sop,
    output logic                    st_eop,
    input  logic                    st_ready,
    output logic [15:0]             stat_frames,
    output logic [15:0]             stat_truncs,
    output logic [1:0]              dbg_wr_state,
    output logic [2:0]              dbg_rd_state
);
    localparam int          DW         = BPS * CHANNELS;
    localparam int          EW         = DW + 3;
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam longint      NPIX       = longint'(VIDEO_W) * longint'(VIDEO_H);
    localparam int          CW         = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);
    localparam int          CTRL_BEATS = (9 + CHANNELS - 1) / CHANNELS;
    localparam logic [3:0]  LAST_CTRL  = 4'(CTRL_BEATS - 1);

    typedef enum logic [1:0] {W_HUNT, W_CAPTURE, W_CLOSE} wr_state_t;
    typedef enum logic [2:0] {R_IDLE, R_CTRL_HDR, R_CTRL_BODY, R_VID_HDR, R_VID_DATA} rd_state_t;

    // FIFO entry layout: {close, sop, eop, data}; close marks a truncation beat.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_full, fifo_empty, wr_en, rd_en;
    logic [EW-1:0] wr_entry, head;
    logic          head_close, head_sop, head_eop;
    logic [DW-1:0] head_data;

    wr_state_t     wr_state_q, wr_state_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    rd_state_t     rd_state_q, rd_state_d;
    logic [3:0]    ctrl_cnt_q, ctrl_cnt_d;
    logic          rdy_q, beat_avail, xfer, frame_inc, trunc_inc;
    logic          beat_sop, beat_eop;
    logic [DW-1:0] beat_data;
    logic [15:0]   frames_q, truncs_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(FIFO_DEPTH));
    assign head       = mem[rd_ptr_q[AW-1:0]];
    assign {head_close, head_sop, head_eop, head_data} = head;

    function automatic logic [3:0] ctrl_nibble(input int k);
        logic [15:0] w, h;
        w = 16'(VIDEO_W);
        h = 16'(VIDEO_H);
        case (k)
            0:       ctrl_nibble = w[15:12];
            1:       ctrl_nibble = w[11:8];
            2:       ctrl_nibble = w[7:4];
            3:       ctrl_nibble = w[3:0];
            4:       ctrl_nibble = h[15:12];
            5:       ctrl_nibble = h[11:8];
            6:       ctrl_nibble = h[7:4];
            7:       ctrl_nibble = h[3:0];
            8:       ctrl_nibble = INTERLACE;
            default: ctrl_nibble = 4'h0;
        endcase
    endfunction

    always_comb begin
        wr_state_d = wr_state_q;
        pix_cnt_d  = pix_cnt_q;
        wr_en      = 1'b0;
        wr_entry   = '0;
        trunc_inc  = 1'b0;
        case (wr_state_q)
            W_HUNT: if (pix_valid && pix_sof) begin
                if (fifo_full) begin
                    wr_state_d = W_CLOSE;
                end else begin
                    wr_en      = 1'b1;
                    wr_entry   = {1'b0, 1'b1, (NPIX == 1), pix_data};
                    pix_cnt_d  = CW'(1);
                    wr_state_d = (NPIX == 1) ? W_HUNT : W_CAPTURE;
                end
            end
            W_CAPTURE: if (pix_valid) begin
                if (pix_sof || fifo_full) begin
                    wr_state_d = W_CLOSE;
                end else begin
                    wr_en     = 1'b1;
                    wr_entry  = {2'b00, (pix_cnt_q == LAST_PIX), pix_data};
                    pix_cnt_d = pix_cnt_q + CW'(1);
                    if (pix_cnt_q == LAST_PIX) wr_state_d = W_HUNT;
                end
            end
            W_CLOSE: if (!fifo_full) begin
                wr_en      = 1'b1;
                wr_entry   = {3'b101, {DW{1'b0}}};
                trunc_inc  = 1'b1;
                wr_state_d = W_HUNT;
            end
            default: wr_state_d = W_HUNT;
        endcase
    end

    // With ready latency 1 the sink has already promised to accept any beat shown while rdy_q is set.
    assign beat_avail = (rd_state_q == R_CTRL_HDR) || (rd_state_q == R_CTRL_BODY) ||
                        (rd_state_q == R_VID_HDR) || ((rd_state_q == R_VID_DATA) && !fifo_empty);
    assign st_valid   = beat_avail && ((READY_LATENCY != 0) ? rdy_q : 1'b1);
    assign xfer       = st_valid && ((READY_LATENCY != 0) ? 1'b1 : st_ready);

    always_comb begin
        rd_state_d = rd_state_q;
        ctrl_cnt_d = ctrl_cnt_q;
        rd_en      = 1'b0;
        frame_inc  = 1'b0;
        beat_sop   = 1'b0;
        beat_eop   = 1'b0;
        beat_data  = '0;
        case (rd_state_q)
            R_IDLE: if (!fifo_empty) begin
                if (head_sop) rd_state_d = (EMIT_CTRL != 0) ? R_CTRL_HDR : R_VID_HDR;
                else          rd_en      = 1'b1;
            end
            R_CTRL_HDR: begin
                beat_sop       = 1'b1;
                beat_data[3:0] = 4'hF;
                if (xfer) begin
                    ctrl_cnt_d = '0;
                    rd_state_d = R_CTRL_BODY;
                end
            end
            R_CTRL_BODY: begin
                for (int c = 0; c < CHANNELS; c++)
                    beat_data[c*BPS +: 4] = ctrl_nibble(int'(ctrl_cnt_q) * CHANNELS + c);
                beat_eop = (ctrl_cnt_q == LAST_CTRL);
                if (xfer) begin
                    ctrl_cnt_d = ctrl_cnt_q + 4'd1;
                    if (ctrl_cnt_q == LAST_CTRL) rd_state_d = R_VID_HDR;
                end
            end
            R_VID_HDR: begin
                beat_sop = 1'b1;
                if (xfer) rd_state_d = R_VID_DATA;
            end
            R_VID_DATA: begin
                beat_eop  = head_eop;
                beat_data = head_data;
                if (xfer) begin
                    rd_en = 1'b1;
                    if (head_eop) begin
                        rd_state_d = R_IDLE;
                        frame_inc  = !head_close;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign st_sop       = st_valid && beat_sop;
    assign st_eop       = st_valid && beat_eop;
    assign st_data      = st_valid ? beat_data : '0;
    assign stat_frames  = frames_q;
    assign stat_truncs  = truncs_q;
    assign dbg_wr_state = wr_state_q;
    assign dbg_rd_state = rd_state_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_state_q <= W_HUNT;
            pix_cnt_q  <= '0;
            rd_state_q <= R_IDLE;
            ctrl_cnt_q <= '0;
            rdy_q      <= 1'b0;
            frames_q   <= '0;
            truncs_q   <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            wr_state_q <= wr_state_d;
            pix_cnt_q  <= pix_cnt_d;
            rd_state_q <= rd_state_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            rdy_q      <= st_ready;
            if (frame_inc) frames_q <= frames_q + 16'd1;
            if (trunc_inc) truncs_q <= truncs_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_camera_vip_packetizer.sv
// Scoreboard bench for camera_vip_packetizer: two instances (RL0 with control packets,
// RL1 video-only) share one pixel stream; a frame-level model fills per-instance queues.
module tb_camera_vip_packetizer;
    localparam int BPS = 8;
    localparam int CH  = 3;
    localparam int DW  = BPS * CH;
    localparam int EW  = DW + 2;
    localparam int VW  = 4;
    localparam int VH  = 2;
    localparam int NPX = VW * VH;
    localparam int DEPTH = 4;
    localparam logic [3:0] ILACE = 4'h0;

    logic          clk, reset_n, pix_valid, pix_sof;
    logic [DW-1:0] pix_data;
    logic [DW-1:0] st_data0, st_data1;
    logic          st_valid0, st_sop0, st_eop0, st_ready0;
    logic          st_valid1, st_sop1, st_eop1, st_ready1;
    logic [15:0]   stat_frames0, stat_truncs0, stat_frames1, stat_truncs1;
    logic [1:0]    dbg_wr0, dbg_wr1;
    logic [2:0]    dbg_rd0, dbg_rd1;

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [DW-1:0] frame_px[NPX];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            frames_exp = 0;
    int            truncs_exp = 0;
    logic          hold_low = 1'b0;
    logic          rdy1_seen = 1'b0;

    camera_vip_packetizer #(
        .BPS(BPS), .CHANNELS(CH), .VIDEO_W(VW), .VIDEO_H(VH), .FIFO_DEPTH(DEPTH),
        .EMIT_CTRL(1), .INTERLACE(ILACE), .READY_LATENCY(0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_data(pix_data), .st_data(st_data0), .st_valid(st_valid0), .st_sop(st_sop0),
        .st_eop(st_eop0), .st_ready(st_ready0), .stat_frames(stat_frames0),
        .stat_truncs(stat_truncs0), .dbg_wr_state(dbg_wr0), .dbg_rd_state(dbg_rd0)
    );

    camera_vip_packetizer #(
        .BPS(BPS), .CHANNELS(CH), .VIDEO_W(VW), .VIDEO_H(VH), .FIFO_DEPTH(DEPTH),
        .EMIT_CTRL(0), .INTERLACE(ILACE), .READY_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_data(pix_data), .st_data(st_data1), .st_valid(st_valid1), .st_sop(st_sop1),
        .st_eop(st_eop1), .st_ready(st_ready1), .stat_frames(stat_frames1),
        .stat_truncs(stat_truncs1), .dbg_wr_state(dbg_wr1), .dbg_rd_state(dbg_rd1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- sink ready generator ----------------
    // Never low two cycles running so paced frames cannot overflow the 4-entry FIFO.
    initial begin
        st_ready0 = 1'b0;
        st_ready1 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold_low) begin
                st_ready0 = 1'b0;
                st_ready1 = 1'b0;
            end else begin
                st_ready0 = st_ready0 ? 1'($urandom_range(0, 1)) : 1'b1;
                st_ready1 = st_ready1 ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    always @(posedge clk) rdy1_seen <= st_ready1;

    // ---------------- reference model ----------------
    task automatic push_both(input logic [EW-1:0] beat, input bit to0, input bit to1);
        if (to0) exp_q0.push_back(beat);
        if (to1) exp_q1.push_back(beat);
    endtask

    task automatic push_frame(input int n_kept, input bit trunc);
        int            nib[9];
        logic [DW-1:0] d;
        nib[0] = (VW / 4096) % 16; nib[1] = (VW / 256) % 16;
        nib[2] = (VW / 16) % 16;   nib[3] = VW % 16;
        nib[4] = (VH / 4096) % 16; nib[5] = (VH / 256) % 16;
        nib[6] = (VH / 16) % 16;   nib[7] = VH % 16;
        nib[8] = int'(ILACE);
        push_both({2'b10, DW'(24'h00000F)}, 1'b1, 1'b0);
        for (int b = 0; b < (9 + CH - 1) / CH; b++) begin
            d = '0;
            for (int c = 0; c < CH; c++)
                if (b * CH + c < 9) d = d | (DW'(nib[b * CH + c]) << (c * BPS));
            push_both({1'b0, (b == (9 + CH - 1) / CH - 1), d}, 1'b1, 1'b0);
        end
        push_both({2'b10, {DW{1'b0}}}, 1'b1, 1'b1);
        for (int i = 0; i < n_kept; i++)
            push_both({1'b0, (!trunc && i == n_kept - 1), frame_px[i]}, 1'b1, 1'b1);
        if (trunc) begin
            push_both({2'b01, {DW{1'b0}}}, 1'b1, 1'b1);
            truncs_exp++;
        end else begin
            frames_exp++;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %0h required %0h", name, got, want);
    endtask

    task automatic check_beat(input int which, input logic [EW-1:0] got);
        logic [EW-1:0] want;
        n_checks++;
        if ((which == 0 && exp_q0.size() == 0) || (which == 1 && exp_q1.size() == 0)) begin
            $display("FAIL dut%0d_beat unexpected got %h required none", which, got);
        end else begin
            if (which == 0) want = exp_q0.pop_front();
            else            want = exp_q1.pop_front();
            if (got === want) n_pass++;
            else $display("FAIL dut%0d_beat got sop/eop/data %h required %h", which, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (st_valid0 && st_ready0) check_beat(0, {st_sop0, st_eop0, st_data0});
            if (st_valid1) begin
                check("dut1_valid_after_ready", 32'(rdy1_seen), 32'd1);
                check_beat(1, {st_sop1, st_eop1, st_data1});
            end
        end
    end

    task automatic check_stats(input string tag);
        check({tag, "_frames0"}, 32'(stat_frames0), 32'(frames_exp));
        check({tag, "_truncs0"}, 32'(stat_truncs0), 32'(truncs_exp));
        check({tag, "_frames1"}, 32'(stat_frames1), 32'(frames_exp));
        check({tag, "_truncs1"}, 32'(stat_truncs1), 32'(truncs_exp));
    endtask

    // ---------------- drivers ----------------
    task automatic drive_cycle(input logic v, input logic s, input logic [DW-1:0] d);
        @(posedge clk); #1;
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
    endtask

    task automatic send_px(input logic s, input logic [DW-1:0] d);
        drive_cycle(1'b1, s, d);
        repeat ($urandom_range(5, 7)) drive_cycle(1'b0, 1'b0, '0);
    endtask

    task automatic new_frame();
        for (int i = 0; i < NPX; i++) frame_px[i] = DW'($urandom);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 800) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (n >= 800) begin
            $display("FAIL %s_drain got q0=%0d q1=%0d required 0", tag, exp_q0.size(), exp_q1.size());
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            n_pass++;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic clean_frame(input bit junk);
        new_frame();
        push_frame(NPX, 1'b0);
        if (junk) begin
            repeat ($urandom_range(2, 4)) send_px(1'b0, DW'($urandom));
            drive_cycle(1'b0, 1'b1, DW'($urandom));
        end
        for (int i = 0; i < NPX; i++) send_px(i == 0, frame_px[i]);
        if (junk) send_px(1'b0, DW'($urandom));
        wait_drain(junk ? "junk" : "clean");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n   = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid0", 32'(st_valid0), 32'd0);
        check("rst_valid1", 32'(st_valid1), 32'd0);
        check("rst_flags0", 32'({st_sop0, st_eop0}), 32'd0);
        check("rst_data0", 32'(st_data0), 32'd0);
        check_stats("rst");
        @(posedge clk); #2 reset_n = 1'b1;

        for (int f = 0; f < 4; f++) clean_frame(1'b0);
        check_stats("clean");
        clean_frame(1'b1);
        check_stats("junk");

        // Early sof after five pixels: that frame is closed, the interrupting frame is skipped.
        new_frame();
        push_frame(5, 1'b1);
        for (int i = 0; i < 5; i++) send_px(i == 0, frame_px[i]);
        for (int i = 0; i < NPX; i++) send_px(i == 0, DW'($urandom));
        wait_drain("early_sof");
        check_stats("early_sof");
        clean_frame(1'b0);
        check_stats("after_early");

        // Sink stalled for a whole frame: only DEPTH pixels fit, then the close beat.
        hold_low = 1'b1;
        repeat (3) drive_cycle(1'b0, 1'b0, '0);
        new_frame();
        push_frame(DEPTH, 1'b1);
        for (int i = 0; i < NPX; i++) drive_cycle(1'b1, i == 0, frame_px[i]);
        repeat (6) drive_cycle(1'b0, 1'b0, '0);
        hold_low = 1'b0;
        wait_drain("overflow");
        check_stats("overflow");
        clean_frame(1'b0);

        // Reset in the middle of video data.
        new_frame();
        push_frame(NPX, 1'b0);
        fork
            for (int i = 0; i < NPX; i++) send_px(i == 0, frame_px[i]);
            begin
                int n = 0;
                while (!(exp_q0.size() <= 6 && exp_q1.size() <= 6) && n < 400) begin
                    @(posedge clk);
                    n++;
                end
                check("reset_reach_vid_data", 32'(n < 400), 32'd1);
                @(posedge clk); #2;
                reset_n = 1'b0;
                exp_q0.delete();
                exp_q1.delete();
                frames_exp = 0;
                truncs_exp = 0;
                @(negedge clk);
                check("midrst_valid0", 32'(st_valid0), 32'd0);
                check("midrst_valid1", 32'(st_valid1), 32'd0);
                check("midrst_eop0", 32'({st_sop0, st_eop0}), 32'd0);
                check_stats("midrst");
                repeat (2) @(posedge clk);
                #2 reset_n = 1'b1;
            end
        join
        repeat (10) drive_cycle(1'b0, 1'b0, '0);
        check("post_rst_idle_valid0", 32'(st_valid0), 32'd0);
        clean_frame(1'b0);
        check_stats("post_rst");

        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
